// File: rtl/audio_pkg.sv
// Shared types and helpers for the stereo PWM audio DAC.
// The sample struct is sized for the widest supported sample; narrower samples use the low bits.
package audio_pkg;

  localparam int AUDIO_W_MAX = 32;

  typedef struct packed {
    logic [AUDIO_W_MAX-1:0] left;
    logic [AUDIO_W_MAX-1:0] right;
  } stereo_sample_t;

  function automatic int unsigned midscale(input int unsigned bits);
    return 32'd1 << (bits - 1);
  endfunction

endpackage

// File: rtl/audio_pwm_dac_if.sv
// Sample stream between the DAC control logic (master) and the sample FIFO (slave).
interface audio_pwm_dac_if #(
    parameter int DEPTH = 4
);
    import audio_pkg::*;

    logic                   push;
    stereo_sample_t         push_data;
    logic                   pop;
    stereo_sample_t         pop_data;
    logic                   full;
    logic                   empty;
    logic [$clog2(DEPTH):0] level;

    modport master (output push, push_data, pop, input pop_data, full, empty, level);
    modport slave  (input push, push_data, pop, output pop_data, full, empty, level);
endinterface

// File: rtl/sample_fifo.sv
// Synchronous FIFO with occupancy count; a pop of an empty FIFO is ignored, so a
// push into an empty FIFO is never forwarded to the read side in the same cycle.
module sample_fifo
    import audio_pkg::*;
#(
    parameter int WIDTH = $bits(stereo_sample_t),
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    audio_pwm_dac_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push, do_pop;

    assign do_pop  = bus.pop && (level_q != '0);
    assign do_push = bus.push && ((level_q != FULL_LVL) || do_pop);

    assign bus.full     = (level_q == FULL_LVL);
    assign bus.empty    = (level_q == '0);
    assign bus.level    = level_q;
    assign bus.pop_data = stereo_sample_t'(mem_q[rd_ptr_q]);

    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end

    // NOTE: storage is deliberately not reset; the level/pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= WIDTH'(bus.push_data);
    end
endmodule

// File: rtl/audio_pwm_dac.sv
// Stereo PWM audio DAC: samples queue in a FIFO, one entry is consumed per carrier
// period and converted to offset-binary duty cycles compared against a free-running counter.
module audio_pwm_dac
    import audio_pkg::*;
#(
    parameter int AUDIO_BIT_WIDTH = 16,
    parameter int PWM_BITS        = 8,
    parameter int FIFO_DEPTH      = 4,
    parameter int ATTEN_SHIFT     = 4
) (
    input  logic                              clk_pixel,
    input  logic                              reset_n,
    input  logic                              sample_valid,
    input  logic signed [AUDIO_BIT_WIDTH-1:0] sample_left,
    input  logic signed [AUDIO_BIT_WIDTH-1:0] sample_right,
    input  logic                              clear_flags,
    output logic                              pwm_left,
    output logic                              pwm_right,
    output logic                              underrun,
    output logic                              overflow,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level
);
    localparam logic [PWM_BITS-1:0] DUTY_MID = PWM_BITS'(midscale(PWM_BITS));

    logic [PWM_BITS-1:0] cnt_q, duty_l_q, duty_r_q;
    logic                pwm_l_q, pwm_r_q;
    logic                underrun_q, underrun_d, overflow_q, overflow_d;
    logic                boundary;

    audio_pwm_dac_if #(.DEPTH(FIFO_DEPTH)) fifo_bus ();

    sample_fifo #(
        .WIDTH ($bits(stereo_sample_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_pixel),
        .rst_n (reset_n),
        .bus   (fifo_bus.slave)
    );

    // Offset binary: attenuate, flip the sign bit, keep the top PWM_BITS bits.
    function automatic logic [PWM_BITS-1:0] to_duty(input logic [AUDIO_W_MAX-1:0] raw);
        logic signed [AUDIO_BIT_WIDTH-1:0] s;
        logic        [AUDIO_BIT_WIDTH-1:0] ob;
        s  = $signed(raw[AUDIO_BIT_WIDTH-1:0]) >>> ATTEN_SHIFT;
        ob = {~s[AUDIO_BIT_WIDTH-1], s[AUDIO_BIT_WIDTH-2:0]};
        return ob[AUDIO_BIT_WIDTH-1 -: PWM_BITS];
    endfunction

    assign boundary           = (cnt_q == '1);
    assign fifo_bus.push      = sample_valid;
    assign fifo_bus.push_data = '{left: AUDIO_W_MAX'(sample_left), right: AUDIO_W_MAX'(sample_right)};
    assign fifo_bus.pop       = boundary;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        underrun_d = underrun_q & ~clear_flags;
        overflow_d = overflow_q & ~clear_flags;
        if (boundary && fifo_bus.empty) underrun_d = 1'b1;
        // A full FIFO that is popped this cycle still has room for the push.
        if (sample_valid && fifo_bus.full && !boundary) overflow_d = 1'b1;
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            duty_l_q   <= DUTY_MID;
            duty_r_q   <= DUTY_MID;
            pwm_l_q    <= 1'b0;
            pwm_r_q    <= 1'b0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
            if (boundary && !fifo_bus.empty) begin
                duty_l_q <= to_duty(fifo_bus.pop_data.left);
                duty_r_q <= to_duty(fifo_bus.pop_data.right);
            end
            pwm_l_q    <= (cnt_q < duty_l_q);
            pwm_r_q    <= (cnt_q < duty_r_q);
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
        end
    end

    assign pwm_left   = pwm_l_q;
    assign pwm_right  = pwm_r_q;
    assign underrun   = underrun_q;
    assign overflow   = overflow_q;
    assign fifo_level = fifo_bus.level;
endmodule
